// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction cache (one 32-bit word per line)
// that serves fetch requests. A miss is filled with four byte reads through the
// memory arbiter. A flush from the ROB aborts any fill in progress.
module icache_responder #(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  Inst_en,
    input  logic [ADDR_WIDTH-1:0] Addr,
    output logic                  Inst_Status_out,
    output logic [31:0]           Inst_out,
    output logic [ADDR_WIDTH-1:0] Inst_pc_out,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_a,
    input  logic [7:0]            mem_din,
    output logic                  o_dbg_state
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    // S_IDLE answers hits and detects misses. S_FETCH runs the four-byte fill.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    // Memory handshake: mem_req asks for the port and mem_a is held stable with it.
    // A cycle with mem_req=1 and mem_gnt=1 transfers the address. The matching byte
    // appears on mem_din in the next cycle, and r_pending marks that cycle.
    state_t                r_state;
    state_t                w_state_nxt;

    // Line storage
    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [31:0]           r_data [LINES];

    // Miss bookkeeping
    logic [ADDR_WIDTH-1:0] r_miss_addr;
    logic [2:0]            r_req_cnt;     // byte addresses granted so far, 0..4
    logic [1:0]            r_recv_cnt;    // bytes received so far, 0..3
    logic                  r_pending;     // a granted byte arrives this cycle
    logic [23:0]           r_buf;         // bytes 0..2; byte 3 comes straight from mem_din

    // Registered outputs
    logic                  r_req;
    logic [ADDR_WIDTH-1:0] r_a;
    logic                  r_status;
    logic [31:0]           r_inst;
    logic [ADDR_WIDTH-1:0] r_pc;

    // Next-state values
    logic [ADDR_WIDTH-1:0] w_miss_addr_nxt;
    logic [2:0]            w_req_cnt_nxt;
    logic [1:0]            w_recv_cnt_nxt;
    logic                  w_pending_nxt;
    logic [23:0]           w_buf_nxt;
    logic                  w_req_nxt;
    logic [ADDR_WIDTH-1:0] w_a_nxt;
    logic                  w_status_nxt;
    logic [31:0]           w_inst_nxt;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic                  w_fill;

    // Address decode
    logic [ADDR_WIDTH-1:0] w_addr_al;
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic [INDEX_BITS-1:0] w_fill_idx;
    logic [TAG_BITS-1:0]   w_fill_tag;
    logic [31:0]           w_fill_word;

    // The low two address bits are dropped, so every byte of a word maps to the same line.
    assign w_addr_al   = Addr & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    assign w_idx       = w_addr_al[INDEX_BITS+1:2];
    assign w_tag       = w_addr_al[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill_idx  = r_miss_addr[INDEX_BITS+1:2];
    assign w_fill_tag  = r_miss_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_fill_word = {mem_din, r_buf};

    // Next-state and output decode. Flush beats everything else.
    always_comb begin
        w_state_nxt     = r_state;
        w_miss_addr_nxt = r_miss_addr;
        w_req_cnt_nxt   = r_req_cnt;
        w_recv_cnt_nxt  = r_recv_cnt;
        w_pending_nxt   = 1'b0;
        w_buf_nxt       = r_buf;
        w_req_nxt       = 1'b0;
        w_a_nxt         = r_a;
        w_status_nxt    = 1'b0;
        w_inst_nxt      = r_inst;
        w_pc_nxt        = r_pc;
        w_fill          = 1'b0;

        if (flush_in) begin
            // Drop the fill, the in-flight byte and any hit response. Keep the lines.
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Inst_en) begin
                        if (w_hit) begin
                            w_status_nxt = 1'b1;
                            w_inst_nxt   = r_data[w_idx];
                            w_pc_nxt     = w_addr_al;
                        end else begin
                            w_state_nxt     = S_FETCH;
                            w_miss_addr_nxt = w_addr_al;
                            w_req_cnt_nxt   = 3'd0;
                            w_recv_cnt_nxt  = 2'd0;
                            w_req_nxt       = 1'b1;
                            w_a_nxt         = w_addr_al;
                        end
                    end
                end
                S_FETCH: begin
                    // Grant side: advance to the next byte address.
                    if (mem_gnt && (r_req_cnt < 3'd4)) begin
                        w_req_cnt_nxt = r_req_cnt + 3'd1;
                        w_pending_nxt = 1'b1;
                    end
                    w_req_nxt = (w_req_cnt_nxt < 3'd4);
                    if (w_req_nxt) begin
                        w_a_nxt = r_miss_addr + ADDR_WIDTH'(w_req_cnt_nxt);
                    end
                    // Data side: collect the byte granted last cycle (little-endian).
                    if (r_pending) begin
                        w_recv_cnt_nxt = r_recv_cnt + 2'd1;
                        case (r_recv_cnt)
                            2'd0: w_buf_nxt[7:0]   = mem_din;
                            2'd1: w_buf_nxt[15:8]  = mem_din;
                            2'd2: w_buf_nxt[23:16] = mem_din;
                            2'd3: begin
                                w_fill        = 1'b1;
                                w_status_nxt  = 1'b1;
                                w_inst_nxt    = w_fill_word;
                                w_pc_nxt      = r_miss_addr;
                                w_state_nxt   = S_IDLE;
                                w_req_nxt     = 1'b0;
                                w_pending_nxt = 1'b0;
                            end
                        endcase
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register. rdy_in low freezes it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    // Miss bookkeeping and registered outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_miss_addr <= '0;
            r_req_cnt   <= 3'd0;
            r_recv_cnt  <= 2'd0;
            r_pending   <= 1'b0;
            r_buf       <= '0;
            r_req       <= 1'b0;
            r_a         <= '0;
            r_status    <= 1'b0;
            r_inst      <= '0;
            r_pc        <= '0;
        end else if (rdy_in) begin
            r_miss_addr <= w_miss_addr_nxt;
            r_req_cnt   <= w_req_cnt_nxt;
            r_recv_cnt  <= w_recv_cnt_nxt;
            r_pending   <= w_pending_nxt;
            r_buf       <= w_buf_nxt;
            r_req       <= w_req_nxt;
            r_a         <= w_a_nxt;
            r_status    <= w_status_nxt;
            r_inst      <= w_inst_nxt;
            r_pc        <= w_pc_nxt;
        end
    end

    // Valid bits. Cleared only by reset and set when a fill completes.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= '0;
        end else if (rdy_in && w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays. A fill always overwrites the line.
    always_ff @(posedge clk_in) begin
        if (rdy_in && w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= w_fill_word;
        end
    end

    assign Inst_Status_out = r_status;
    assign Inst_out        = r_inst;
    assign Inst_pc_out     = r_pc;
    assign mem_req         = r_req;
    assign mem_a           = r_a;
    assign o_dbg_state     = (r_state == S_FETCH);

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed vector table, hand sequences for
// flush/reset, then randomized traffic against a behavioural cache model.
module tb_icache_responder;

    localparam int NLINES = 256;

    logic        clk_in   = 1'b0;
    logic        rst_in   = 1'b1;
    logic        rdy_in   = 1'b1;
    logic        flush_in = 1'b0;
    logic        Inst_en  = 1'b0;
    logic [31:0] Addr     = '0;
    logic        Inst_Status_out;
    logic [31:0] Inst_out;
    logic [31:0] Inst_pc_out;
    logic        mem_req;
    logic        mem_gnt  = 1'b0;
    logic [31:0] mem_a;
    logic [7:0]  mem_din  = '0;
    logic        o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic        gnt;
        logic        fl;
        logic [7:0]  din;
        logic        st;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        req;
        logic [31:0] a;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state
    bit          m_valid [NLINES];
    logic [31:0] m_tag   [NLINES];
    logic [31:0] m_data  [NLINES];
    bit          m_busy;
    logic [31:0] m_addr;
    int          m_ngrant;
    int          m_nrecv;
    bit          m_inflight;
    logic        exp_st;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic [31:0] exp_q[$];

    icache_responder dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .flush_in        (flush_in),
        .Inst_en         (Inst_en),
        .Addr            (Addr),
        .Inst_Status_out (Inst_Status_out),
        .Inst_out        (Inst_out),
        .Inst_pc_out     (Inst_pc_out),
        .mem_req         (mem_req),
        .mem_gnt         (mem_gnt),
        .mem_a           (mem_a),
        .mem_din         (mem_din),
        .o_dbg_state     (o_dbg_state)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [31:0] addr, input logic gnt,
                                input logic fl, input logic [7:0] din, input logic st,
                                input logic [31:0] inst, input logic [31:0] pc,
                                input logic req, input logic [31:0] a);
        vec_t v;
        v.en = en; v.addr = addr; v.gnt = gnt; v.fl = fl; v.din = din;
        v.st = st; v.inst = inst; v.pc = pc; v.req = req; v.a = a;
        return v;
    endfunction

    // Memory contents seen by the random phase
    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        logic [31:0] h;
        h = (a ^ 32'h5A5A_0000) * 32'h9E37_79B1;
        return h[31:24];
    endfunction

    // Driver: apply one cycle of inputs, then compare the registered outputs
    task automatic apply_vec(input vec_t v, input string tag);
        Inst_en  = v.en;
        Addr     = v.addr;
        mem_gnt  = v.gnt;
        flush_in = v.fl;
        mem_din  = v.din;
        rdy_in   = 1'b1;
        @(posedge clk_in); #1;
        chk($sformatf("%s.status", tag), 32'(Inst_Status_out), 32'(v.st));
        chk($sformatf("%s.inst", tag), Inst_out, v.inst);
        chk($sformatf("%s.pc", tag), Inst_pc_out, v.pc);
        chk($sformatf("%s.req", tag), 32'(mem_req), 32'(v.req));
        if (v.req) chk($sformatf("%s.mem_a", tag), mem_a, v.a);
    endtask

    task automatic chk_all_zero(input string tag);
        chk($sformatf("%s.status", tag), 32'(Inst_Status_out), 32'h0);
        chk($sformatf("%s.inst", tag), Inst_out, 32'h0);
        chk($sformatf("%s.pc", tag), Inst_pc_out, 32'h0);
        chk($sformatf("%s.req", tag), 32'(mem_req), 32'h0);
        chk($sformatf("%s.mem_a", tag), mem_a, 32'h0);
        chk($sformatf("%s.dbg", tag), 32'(o_dbg_state), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        Inst_en = 1'b0; flush_in = 1'b0; mem_gnt = 1'b0; rdy_in = 1'b1;
        mem_din = '0; Addr = '0;
        #2 rst_in = 1'b0;
        @(posedge clk_in); #1;
        chk_all_zero(tag);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NLINES; i++) m_valid[i] = 1'b0;
        m_busy = 1'b0; m_addr = '0; m_ngrant = 0; m_nrecv = 0; m_inflight = 1'b0;
        exp_st = 1'b0; exp_inst = '0; exp_pc = '0;
        exp_q.delete();
    endtask

    // Randomized traffic checked against the cache model
    task automatic run_random(input int ncycles);
        logic        rdy, en, fl, gnt, granted, dut_rdy_pulse;
        logic [31:0] addr, gaddr, word, al;
        int          idx;
        for (int c = 0; c < ncycles; c++) begin
            rdy  = ($urandom_range(0, 9) != 0);
            en   = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 29) == 0);
            addr = 32'h0001_0000 + (32'($urandom_range(0, 3)) << 10)
                 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
            gnt  = rdy && m_busy && (m_ngrant < 4) && ($urandom_range(0, 3) != 0);
            Inst_en = en; Addr = addr; flush_in = fl; rdy_in = rdy; mem_gnt = gnt;
            granted = gnt;
            gaddr   = mem_a;
            @(posedge clk_in); #1;
            if (granted) mem_din = mem_rd(gaddr);
            else if (rdy) mem_din = 8'($urandom);

            if (rdy) begin
                exp_st = 1'b0;
                if (fl) begin
                    m_busy = 1'b0;
                    m_inflight = 1'b0;
                end else if (!m_busy) begin
                    if (en) begin
                        al  = addr & 32'hFFFF_FFFC;
                        idx = int'((al >> 2) % NLINES);
                        if (m_valid[idx] && m_tag[idx] == (al >> 10)) begin
                            exp_st = 1'b1; exp_inst = m_data[idx]; exp_pc = al;
                        end else begin
                            m_busy = 1'b1; m_addr = al; m_ngrant = 0; m_nrecv = 0;
                            m_inflight = 1'b0;
                        end
                    end
                end else begin
                    if (m_inflight) m_nrecv++;
                    m_inflight = granted;
                    if (granted) m_ngrant++;
                    if (m_nrecv == 4) begin
                        word = {mem_rd(m_addr + 32'd3), mem_rd(m_addr + 32'd2),
                                mem_rd(m_addr + 32'd1), mem_rd(m_addr)};
                        idx = int'((m_addr >> 2) % NLINES);
                        m_valid[idx] = 1'b1; m_tag[idx] = m_addr >> 10; m_data[idx] = word;
                        exp_st = 1'b1; exp_inst = word; exp_pc = m_addr;
                        m_busy = 1'b0;
                    end
                end
                if (exp_st) exp_q.push_back(exp_inst);
            end

            chk("rnd.status", 32'(Inst_Status_out), 32'(exp_st));
            chk("rnd.inst", Inst_out, exp_inst);
            chk("rnd.pc", Inst_pc_out, exp_pc);
            chk("rnd.req", 32'(mem_req), 32'(m_busy && m_ngrant < 4));
            chk("rnd.dbg", 32'(o_dbg_state), 32'(m_busy));
            if (m_busy && m_ngrant < 4) chk("rnd.mem_a", mem_a, m_addr + 32'(m_ngrant));

            // Scoreboard: every response pulse must match the oldest expected word
            dut_rdy_pulse = rdy && Inst_Status_out;
            if (dut_rdy_pulse) begin
                if (exp_q.size() == 0) begin
                    chk("sb.unexpected_resp", 32'h1, 32'h0);
                end else begin
                    chk("sb.resp", Inst_out, exp_q.pop_front());
                end
            end
        end
        rdy_in = 1'b1; Inst_en = 1'b0; flush_in = 1'b0; mem_gnt = 1'b0;
        chk("sb.drain", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        // Reset
        do_reset("reset");

        // Miss at 0x1000 with continuous grant
        tbl.push_back(mk(1, 32'h1000, 0, 0, 8'h00, 0, 32'h0, 32'h0, 1, 32'h1000));
        tbl.push_back(mk(1, 32'h1000, 1, 0, 8'h00, 0, 32'h0, 32'h0, 1, 32'h1001));
        tbl.push_back(mk(1, 32'h1000, 1, 0, 8'h13, 0, 32'h0, 32'h0, 1, 32'h1002));
        tbl.push_back(mk(1, 32'h1000, 1, 0, 8'h05, 0, 32'h0, 32'h0, 1, 32'h1003));
        tbl.push_back(mk(1, 32'h1000, 1, 0, 8'h10, 0, 32'h0, 32'h0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h1000, 1, 0, 8'h00, 1, 32'h00100513, 32'h1000, 0, 32'h0));
        // Hits, including unaligned address
        tbl.push_back(mk(1, 32'h1000, 0, 0, 8'h00, 1, 32'h00100513, 32'h1000, 0, 32'h0));
        tbl.push_back(mk(1, 32'h1002, 0, 0, 8'h00, 1, 32'h00100513, 32'h1000, 0, 32'h0));
        tbl.push_back(mk(0, 32'h1000, 0, 0, 8'h00, 0, 32'h00100513, 32'h1000, 0, 32'h0));
        // Conflict miss at 0x1400, then 0x1000 misses again
        tbl.push_back(mk(1, 32'h1400, 0, 0, 8'h00, 0, 32'h00100513, 32'h1000, 1, 32'h1400));
        tbl.push_back(mk(1, 32'h1400, 1, 0, 8'h00, 0, 32'h00100513, 32'h1000, 1, 32'h1401));
        tbl.push_back(mk(1, 32'h1400, 1, 0, 8'hEF, 0, 32'h00100513, 32'h1000, 1, 32'h1402));
        tbl.push_back(mk(1, 32'h1400, 1, 0, 8'hBE, 0, 32'h00100513, 32'h1000, 1, 32'h1403));
        tbl.push_back(mk(1, 32'h1400, 1, 0, 8'hAD, 0, 32'h00100513, 32'h1000, 0, 32'h0));
        tbl.push_back(mk(1, 32'h1400, 0, 0, 8'hDE, 1, 32'hDEADBEEF, 32'h1400, 0, 32'h0));
        tbl.push_back(mk(1, 32'h1000, 0, 0, 8'h00, 0, 32'hDEADBEEF, 32'h1400, 1, 32'h1000));
        tbl.push_back(mk(1, 32'h1000, 1, 0, 8'h00, 0, 32'hDEADBEEF, 32'h1400, 1, 32'h1001));
        tbl.push_back(mk(1, 32'h1000, 1, 0, 8'h11, 0, 32'hDEADBEEF, 32'h1400, 1, 32'h1002));
        tbl.push_back(mk(1, 32'h1000, 1, 0, 8'h22, 0, 32'hDEADBEEF, 32'h1400, 1, 32'h1003));
        tbl.push_back(mk(1, 32'h1000, 1, 0, 8'h33, 0, 32'hDEADBEEF, 32'h1400, 0, 32'h0));
        tbl.push_back(mk(1, 32'h1000, 0, 0, 8'h44, 1, 32'h44332211, 32'h1000, 0, 32'h0));
        tbl.push_back(mk(1, 32'h1000, 0, 0, 8'h00, 1, 32'h44332211, 32'h1000, 0, 32'h0));
        // Miss at 0x2000, grant pattern 1,0,0,1,1,0,1, garbage on non-data cycles
        tbl.push_back(mk(1, 32'h2000, 0, 0, 8'h00, 0, 32'h44332211, 32'h1000, 1, 32'h2000));
        tbl.push_back(mk(1, 32'h2000, 1, 0, 8'h00, 0, 32'h44332211, 32'h1000, 1, 32'h2001));
        tbl.push_back(mk(1, 32'h5550, 0, 0, 8'hA1, 0, 32'h44332211, 32'h1000, 1, 32'h2001));
        tbl.push_back(mk(0, 32'h2000, 0, 0, 8'h77, 0, 32'h44332211, 32'h1000, 1, 32'h2001));
        tbl.push_back(mk(1, 32'h2000, 1, 0, 8'h66, 0, 32'h44332211, 32'h1000, 1, 32'h2002));
        tbl.push_back(mk(1, 32'h2000, 1, 0, 8'hB2, 0, 32'h44332211, 32'h1000, 1, 32'h2003));
        tbl.push_back(mk(1, 32'h2000, 0, 0, 8'hC3, 0, 32'h44332211, 32'h1000, 1, 32'h2003));
        tbl.push_back(mk(1, 32'h2000, 1, 0, 8'hFF, 0, 32'h44332211, 32'h1000, 0, 32'h0));
        tbl.push_back(mk(1, 32'h2000, 0, 0, 8'hD4, 1, 32'hD4C3B2A1, 32'h2000, 0, 32'h0));

        for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Flush after two bytes of a miss at 0x3000
        apply_vec(mk(1, 32'h3000, 0, 0, 8'h00, 0, 32'hD4C3B2A1, 32'h2000, 1, 32'h3000), "fl.req");
        apply_vec(mk(1, 32'h3000, 1, 0, 8'h00, 0, 32'hD4C3B2A1, 32'h2000, 1, 32'h3001), "fl.g0");
        apply_vec(mk(1, 32'h3000, 1, 0, 8'h01, 0, 32'hD4C3B2A1, 32'h2000, 1, 32'h3002), "fl.g1");
        apply_vec(mk(1, 32'h3000, 1, 0, 8'h02, 0, 32'hD4C3B2A1, 32'h2000, 1, 32'h3003), "fl.g2");
        apply_vec(mk(1, 32'h3000, 1, 1, 8'h03, 0, 32'hD4C3B2A1, 32'h2000, 0, 32'h0), "fl.flush");
        apply_vec(mk(0, 32'h3000, 0, 0, 8'h03, 0, 32'hD4C3B2A1, 32'h2000, 0, 32'h0), "fl.after1");
        apply_vec(mk(0, 32'h3000, 0, 0, 8'h04, 0, 32'hD4C3B2A1, 32'h2000, 0, 32'h0), "fl.after2");
        apply_vec(mk(1, 32'h3000, 0, 0, 8'h00, 0, 32'hD4C3B2A1, 32'h2000, 1, 32'h3000), "fl.rereq");
        apply_vec(mk(1, 32'h3000, 1, 0, 8'h00, 0, 32'hD4C3B2A1, 32'h2000, 1, 32'h3001), "fl.r0");
        apply_vec(mk(1, 32'h3000, 1, 0, 8'h93, 0, 32'hD4C3B2A1, 32'h2000, 1, 32'h3002), "fl.r1");
        apply_vec(mk(1, 32'h3000, 1, 0, 8'h82, 0, 32'hD4C3B2A1, 32'h2000, 1, 32'h3003), "fl.r2");
        apply_vec(mk(1, 32'h3000, 1, 0, 8'h71, 0, 32'hD4C3B2A1, 32'h2000, 0, 32'h0), "fl.r3");
        apply_vec(mk(1, 32'h3000, 0, 0, 8'h60, 1, 32'h60718293, 32'h3000, 0, 32'h0), "fl.fill");
        apply_vec(mk(1, 32'h3000, 0, 0, 8'h00, 1, 32'h60718293, 32'h3000, 0, 32'h0), "fl.hit");
        apply_vec(mk(1, 32'h3000, 0, 1, 8'h00, 0, 32'h60718293, 32'h3000, 0, 32'h0), "fl.hitflush");
        apply_vec(mk(1, 32'h3000, 0, 0, 8'h00, 1, 32'h60718293, 32'h3000, 0, 32'h0), "fl.kept");

        // Asynchronous reset in the middle of a fill
        apply_vec(mk(1, 32'h1000, 0, 0, 8'h00, 0, 32'h60718293, 32'h3000, 1, 32'h1000), "rs.req");
        apply_vec(mk(1, 32'h1000, 1, 0, 8'h00, 0, 32'h60718293, 32'h3000, 1, 32'h1001), "rs.g0");
        apply_vec(mk(1, 32'h1000, 1, 0, 8'h78, 0, 32'h60718293, 32'h3000, 1, 32'h1002), "rs.g1");
        apply_vec(mk(1, 32'h1000, 1, 0, 8'h56, 0, 32'h60718293, 32'h3000, 1, 32'h1003), "rs.g2");
        apply_vec(mk(1, 32'h1000, 1, 0, 8'h34, 0, 32'h60718293, 32'h3000, 0, 32'h0), "rs.g3");
        apply_vec(mk(1, 32'h1000, 0, 0, 8'h12, 1, 32'h12345678, 32'h1000, 0, 32'h0), "rs.fill");
        apply_vec(mk(1, 32'h1000, 0, 0, 8'h00, 1, 32'h12345678, 32'h1000, 0, 32'h0), "rs.hit");
        apply_vec(mk(1, 32'h5000, 0, 0, 8'h00, 0, 32'h12345678, 32'h1000, 1, 32'h5000), "rs.miss");
        apply_vec(mk(1, 32'h5000, 1, 0, 8'h00, 0, 32'h12345678, 32'h1000, 1, 32'h5001), "rs.mg0");
        #2 rst_in = 1'b0;
        #1 chk_all_zero("rs.async");
        @(posedge clk_in); #1;
        chk_all_zero("rs.held");
        mem_gnt = 1'b0;
        rst_in = 1'b1;
        apply_vec(mk(1, 32'h1000, 0, 0, 8'h00, 0, 32'h0, 32'h0, 1, 32'h1000), "rs.remiss");

        // Randomized phase
        do_reset("rnd_reset");
        model_reset();
        run_random(4000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-cache responder on the fetch interface. Serves Inst_en/Addr requests from the fetch stage and returns Inst_Status_out/Inst_out.
- Direct-mapped, one 32-bit word per line.
- On a miss, fetches the word as four byte reads from the shared memory port through the memory arbiter's req/gnt handshake. Then it fills the line and responds.
- flush_in, raised by the ROB on redirect, aborts any miss in progress.

Parameters:
INDEX_BITS, 8, log2 number of lines (256); index = Addr[INDEX_BITS+1:2], tag = Addr[31:INDEX_BITS+2]
ADDR_WIDTH, 32, byte-address width

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; 0 freezes all state
flush_in  input  1  abort outstanding miss, drop any response due
Inst_en  input  1  fetch request valid
Addr  input  32  fetch byte address; Addr[1:0] ignored
Inst_Status_out  output  1  one-cycle pulse: Inst_out/Inst_pc_out valid
Inst_out  output  32  instruction word
Inst_pc_out  output  32  word-aligned address of Inst_out (fetch compares against its pc)
mem_req  output  1  request for memory port
mem_gnt  input  1  port granted this cycle
mem_a  output  32  byte address; driven while mem_req=1, meaningful when mem_gnt=1
mem_din  input  8  read byte, valid the cycle after a granted cycle

Behaviour:
- Reset (rst_in=0, async):
  - All valid bits cleared; FSM=IDLE.
  - Inst_Status_out=0, Inst_out=0, Inst_pc_out=0, mem_req=0, mem_a=0.
  - Counters and pending flag cleared.
- rdy_in=0: all registers hold, including outputs. The system guarantees mem_gnt=0 while not ready and holds mem_din.
- Inst_Status_out defaults to 0 every ready cycle unless set as described below.
- State IDLE:
  - Inst_en=1 and hit (valid[index] and tag match): next cycle Inst_Status_out=1, Inst_out=line, Inst_pc_out={Addr[31:2],2'b00}. Hit latency is 1 cycle; back-to-back hits are allowed every cycle.
  - Inst_en=1 and miss: latch miss_addr={Addr[31:2],2'b00}, req_cnt=0, recv_cnt=0, go to FETCH. No response.
- State FETCH:
  - mem_req=1 while req_cnt<4.
  - mem_a=miss_addr+req_cnt, registered so it is stable in the grant cycle.
  - On each cycle with mem_gnt=1 and req_cnt<4: req_cnt increments and pending is set for the next cycle.
  - Cycle after a grant: mem_din is written to buffer byte recv_cnt (little-endian, byte 0 = bits 7:0), then recv_cnt increments.
  - On the edge that samples the 4th byte:
    - write data/tag, set valid[index];
    - Inst_Status_out=1, Inst_out=assembled word, Inst_pc_out=miss_addr;
    - mem_req=0; return to IDLE.
  - Inst_en and Addr are ignored in FETCH; the fetch stage re-presents its pc until it sees a response.
  - With continuous grant, requested in cycle 0: grants in cycles 1-4, bytes in cycles 2-5, Inst_Status_out=1 in cycle 6.
- flush_in=1 (ready cycle, any state) has highest priority:
  - Next state IDLE; mem_req=0 and Inst_Status_out=0 next cycle.
  - A line being filled is not written; a byte still in flight is discarded.
  - Valid array is retained.
  - A hit presented in the same cycle produces no response.
- Conflict miss overwrites the line (tag and data) unconditionally.
- Fill completing for address X makes the next-cycle request to X a hit.
- Address arithmetic: miss_addr + req_cnt is 32-bit, and req_cnt is 0..3, so it never crosses a word.

Test Plan:
1. Reset, then Inst_en=1, Addr=0x1000, mem_gnt=1 held, mem_din bytes 0x13,0x05,0x10,0x00 -> mem_a 0x1000..0x1003 in cycles 1-4; cycle 6: Inst_Status_out=1, Inst_out=0x00100513, Inst_pc_out=0x1000, mem_req=0.
2. Then Addr=0x1000 -> Inst_Status_out=1 next cycle, Inst_out=0x00100513, mem_req stays 0; Addr=0x1002 gives the same result.
3. Addr=0x1400 (same index, different tag) -> miss, fill with 0xDEADBEEF; then Addr=0x1000 -> miss again (line replaced), new fill.
4. Miss at 0x2000 with mem_gnt pattern 1,0,0,1,1,0,1 -> mem_a advances only after granted cycles; Inst_out correct; status one cycle after 4th byte.
5. Miss at 0x3000, flush_in=1 after 2 bytes received -> mem_req=0 next cycle, no Inst_Status_out; a later request to 0x3000 misses and refetches all 4 bytes.
6. rst_in pulled low mid-FETCH between clock edges -> all outputs 0 immediately; after release, Addr=0x1000 (previously cached) misses.
